// File: rtl/gpu_axil_regfile_if.sv
// gpu_axil_regfile_if: AXI4-Lite bus bundle between the PS initiator and the GPU register file
interface gpu_axil_regfile_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gpu_axil_regfile.sv
// gpu_axil_regfile: AXI4-Lite register map for the sprite GPU with frame-synchronous shadow->active commit
module gpu_axil_regfile #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 7,
    parameter int RAM_ADDR_W           = 12,
    parameter int N_SPRITES            = 4
) (
    input  logic                             s00_axi_aclk,
    input  logic                             s00_axi_aresetn,
    gpu_axil_regfile_if.slave                s00_axi,
    input  logic                             frame_start,
    output logic [11:0]                      bg_color,
    output logic [N_SPRITES-1:0]             sprite_en,
    output logic [30*N_SPRITES-1:0]          spr_word_a,
    output logic [12*N_SPRITES-1:0]          spr_word_b,
    output logic [RAM_ADDR_W*N_SPRITES-1:0]  spr_addr
);
    localparam int N_REG = 2 + 3 * N_SPRITES;
    localparam int IDX_W = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int DW    = C_S00_AXI_DATA_WIDTH;

    // Implemented bits of each storage word; everything else reads back as zero
    function automatic logic [31:0] f_mask(input int i);
        return i == 0 ? 32'hFFF :
               i == 1 ? 32'((33'd1 << N_SPRITES) - 33'd1) :
               (i - 2) % 3 == 0 ? 32'h3FFF_FFFF :
               (i - 2) % 3 == 1 ? 32'hFFF :
               32'((33'd1 << RAM_ADDR_W) - 33'd1);
    endfunction

    function automatic logic f_idx_ok(input logic [IDX_W-1:0] idx);
        return 32'(idx) < N_REG || 32'(idx) == 14 || 32'(idx) == 15;
    endfunction

    logic                   r_live;
    logic                   r_aw_held;
    logic                   r_w_held;
    logic [IDX_W-1:0]       r_aw_idx;
    logic [DW-1:0]          r_w_data;
    logic [DW/8-1:0]        r_w_strb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [DW-1:0]          r_rdata;
    logic [N_REG-1:0][31:0] r_sh;
    logic [N_REG-1:0][31:0] r_act;
    logic                   r_pending;
    logic [15:0]            r_frame_cnt;

    logic                   w_awready;
    logic                   w_wready;
    logic                   w_arready;
    logic                   w_wr_go;
    logic                   w_commit_req;
    logic [IDX_W-1:0]       w_ar_idx;
    logic [31:0]            w_bmask;
    logic [31:0]            w_rd_word;
    logic                   w_unused;

    // Ready outputs stay low during reset and until the first clock after it
    assign w_awready    = r_live && !r_aw_held && !r_bvalid;
    assign w_wready     = r_live && !r_w_held && !r_bvalid;
    assign w_arready    = r_live && !r_rvalid;
    assign w_wr_go      = r_aw_held && r_w_held;
    assign w_bmask      = {{8{r_w_strb[3]}}, {8{r_w_strb[2]}}, {8{r_w_strb[1]}}, {8{r_w_strb[0]}}};
    assign w_commit_req = w_wr_go && r_aw_idx == IDX_W'(15) && r_w_strb[0] && r_w_data[0];
    assign w_ar_idx     = s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign w_unused     = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0], r_act};

    assign s00_axi.awready = w_awready;
    assign s00_axi.wready  = w_wready;
    assign s00_axi.bvalid  = r_bvalid;
    assign s00_axi.bresp   = r_bresp;
    assign s00_axi.arready = w_arready;
    assign s00_axi.rvalid  = r_rvalid;
    assign s00_axi.rresp   = r_rresp;
    assign s00_axi.rdata   = r_rdata;

    assign bg_color  = r_act[0][11:0];
    assign sprite_en = r_act[1][N_SPRITES-1:0];
    for (genvar k = 0; k < N_SPRITES; k++) begin : g_spr
        assign spr_word_a[30*k +: 30]                 = r_act[2+3*k][29:0];
        assign spr_word_b[12*k +: 12]                 = r_act[3+3*k][11:0];
        assign spr_addr[RAM_ADDR_W*k +: RAM_ADDR_W]   = r_act[4+3*k][RAM_ADDR_W-1:0];
    end

    // Read mux over the shadow copy; status word reports live commit/frame state
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < N_REG; i++)
            if (w_ar_idx == IDX_W'(i)) w_rd_word = r_sh[i];
        if (w_ar_idx == IDX_W'(14)) w_rd_word = {15'd0, r_pending, r_frame_cnt};
    end

    // Hold AW and W independently; once both are held the write fires and the response is raised
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            r_live <= 1'b1;
            if (s00_axi.awvalid && w_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
            end
            if (s00_axi.wvalid && w_wready) begin
                r_w_held <= 1'b1;
                r_w_data <= s00_axi.wdata;
                r_w_strb <= s00_axi.wstrb;
            end
            if (w_wr_go) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= f_idx_ok(r_aw_idx) ? 2'b00 : 2'b10;
            end else if (s00_axi.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Byte-strobed update of the shadow registers; unmapped indices match no word and are dropped
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_sh <= '0;
        end else if (w_wr_go) begin
            for (int i = 0; i < N_REG; i++)
                if (r_aw_idx == IDX_W'(i))
                    r_sh[i] <= ((r_sh[i] & ~w_bmask) | (r_w_data & w_bmask)) & f_mask(i);
        end
    end

    // Frame counter and commit: a pending request copies shadow to active at the next frame_start
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_act       <= '0;
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (frame_start && r_pending) r_act <= r_sh;
            r_pending <= w_commit_req || (r_pending && !frame_start);
        end
    end

    // Registered read response held stable until accepted
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else if (s00_axi.arvalid && w_arready) begin
            r_rvalid <= 1'b1;
            r_rresp  <= f_idx_ok(w_ar_idx) ? 2'b00 : 2'b10;
            r_rdata  <= f_idx_ok(w_ar_idx) ? DW'(w_rd_word) : '0;
        end else if (s00_axi.rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gpu_axil_regfile.sv
// tb_gpu_axil_regfile: directed and random AXI4-Lite traffic against a register-map reference model
module tb_gpu_axil_regfile;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic [11:0]     bg_color;
    logic [N-1:0]    sprite_en;
    logic [30*N-1:0] spr_word_a;
    logic [12*N-1:0] spr_word_b;
    logic [12*N-1:0] spr_addr;

    gpu_axil_regfile_if bus ();

    gpu_axil_regfile #(.N_SPRITES(N)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (bus),
        .frame_start     (frame_start),
        .bg_color        (bg_color),
        .sprite_en       (sprite_en),
        .spr_word_a      (spr_word_a),
        .spr_word_b      (spr_word_b),
        .spr_addr        (spr_addr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_sh  [16];
    logic [31:0] m_act [16];
    bit          m_pend;
    int          m_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field width of each register as laid out in the register map
    function automatic logic [31:0] field_mask(input int idx);
        if (idx == 0) return 32'hFFF;
        if (idx == 1) return (32'd1 << N) - 1;
        if (idx >= 2 && idx < 2 + 3 * N) begin
            if ((idx - 2) % 3 == 0) return 32'h3FFF_FFFF;
            return 32'hFFF;
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx == 14) return {15'd0, m_pend, 16'(m_cnt)};
        if (idx < 14) return m_sh[idx];
        return 32'h0;
    endfunction

    function automatic logic [1:0] m_resp(input int idx);
        return (idx < 16) ? 2'b00 : 2'b10;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] bm;
        bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (idx < 14) m_sh[idx] = ((m_sh[idx] & ~bm) | (d & bm)) & field_mask(idx);
        else if (idx == 15 && s[0] && d[0]) m_pend = 1'b1;
    endtask

    task automatic m_frame();
        m_cnt = (m_cnt + 1) & 32'hFFFF;
        if (m_pend) begin
            for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
            m_pend = 1'b0;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_pend = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [30*N-1:0] ea;
        logic [12*N-1:0] eb;
        logic [12*N-1:0] ed;
        for (int k = 0; k < N; k++) begin
            ea[30*k +: 30] = m_act[2+3*k][29:0];
            eb[12*k +: 12] = m_act[3+3*k][11:0];
            ed[12*k +: 12] = m_act[4+3*k][11:0];
        end
        chk({tag, ".bg"}, bg_color, m_act[0][11:0]);
        chk({tag, ".en"}, sprite_en, m_act[1][N-1:0]);
        chk({tag, ".a"}, spr_word_a, ea);
        chk({tag, ".b"}, spr_word_b, eb);
        chk({tag, ".addr"}, spr_addr, ed);
    endtask

    task automatic idle_bus();
        bus.awvalid = 0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arprot = '0;
        bus.rready  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_bus();
        frame_start = 1'b0;
        m_clear();
        repeat (2) @(negedge clk);
        chk("rst.ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk("rst.valid", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, 6'd0);
        chk("rst.rdata", bus.rdata, 32'h0);
        check_outputs("rst");
        rst_n = 1'b1;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        @(negedge clk);
        for (int t = 0; t < 100 && !(aw_done && w_done); t++) begin
            if (t == aw_dly) begin bus.awvalid = 1; bus.awaddr = a; bus.awprot = 3'($urandom); end
            if (t == w_dly) begin bus.wvalid = 1; bus.wdata = d; bus.wstrb = s; end
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            if (aw_hs) begin bus.awvalid = 0; aw_done = 1; end
            if (w_hs) begin bus.wvalid = 0; w_done = 1; end
        end
        chk("wr.handshake", {aw_done, w_done}, 2'b11);
        chk("wr.bvalid_early", bus.bvalid, 1'b0);
        @(negedge clk);
        chk("wr.bvalid_rise", bus.bvalid, 1'b1);
        resp = bus.bresp;
        repeat (b_dly) begin
            @(negedge clk);
            chk("wr.bvalid_hold", bus.bvalid, 1'b1);
            chk("wr.no_accept", {bus.awready, bus.wready}, 2'b00);
        end
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        chk("wr.bvalid_drop", bus.bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [6:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        @(negedge clk);
        bus.arvalid = 1;
        bus.araddr  = a;
        for (int t = 0; t < 20 && !hs; t++) begin
            hs = bus.arready;
            @(negedge clk);
        end
        bus.arvalid = 0;
        chk("rd.handshake", hs, 1'b1);
        chk("rd.rvalid", bus.rvalid, 1'b1);
        d    = bus.rdata;
        resp = bus.rresp;
        repeat (r_dly) begin
            @(negedge clk);
            chk("rd.hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, d, resp});
        end
        bus.rready = 1;
        @(negedge clk);
        bus.rready = 0;
        chk("rd.rvalid_drop", bus.rvalid, 1'b0);
    endtask

    task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] resp;
        axi_write({idx[4:0], 2'($urandom)}, d, s, aw_dly, w_dly, b_dly, resp);
        chk($sformatf("wr.resp[%0d]", idx), resp, m_resp(idx));
        m_write(idx, d, s);
        check_outputs("wr");
    endtask

    task automatic do_read(input int idx, input int r_dly);
        logic [31:0] d;
        logic [1:0]  resp;
        axi_read({idx[4:0], 2'($urandom)}, r_dly, d, resp);
        chk($sformatf("rd.data[%0d]", idx), d, m_read(idx));
        chk($sformatf("rd.resp[%0d]", idx), resp, m_resp(idx));
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        m_frame();
        check_outputs("frame");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_bus();
        do_reset();

        do_write(0, 32'h0000_0ABC, 4'hF, 0, 0, 0);
        do_write(15, 32'h1, 4'hF, 0, 0, 0);
        chk("bg.before_frame", bg_color, 12'h000);
        pulse_frame();
        chk("bg.after_frame", bg_color, 12'hABC);

        do_write(2, 32'h0340_A032, 4'hF, 0, 0, 0);
        do_write(3, 32'h0000_0C2D, 4'hF, 0, 0, 0);
        do_write(4, 32'h0, 4'hF, 0, 0, 0);
        do_write(1, 32'h1, 4'hF, 0, 0, 0);
        do_write(15, 32'h1, 4'hF, 0, 0, 0);
        pulse_frame();
        chk("spr0.word_a", spr_word_a[29:0], 30'h0340_A032);
        chk("spr0.word_b", spr_word_b[11:0], 12'hC2D);
        chk("spr0.en", sprite_en, 4'b0001);

        do_write(5, 32'h1234_5678, 4'hF, 3, 0, 5);
        do_read(5, 2);

        do_write(0, 32'h0000_5500, 4'b0010, 0, 0, 0);
        do_read(0, 0);
        chk("strb.model", m_sh[0], 32'h5BC);

        do_write(20, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
        do_read(20, 1);
        do_read(0, 0);

        @(negedge clk);
        bus.awvalid = 1; bus.awaddr = 7'h08; bus.wvalid = 1; bus.wdata = 32'hFFF; bus.wstrb = 4'hF;
        @(negedge clk);
        do_reset();
        repeat (3) @(negedge clk);
        chk("abort.bvalid", bus.bvalid, 1'b0);
        do_read(2, 0);

        repeat (3) pulse_frame();
        do_read(14, 0);
        chk("status.cnt3", m_read(14), 32'h0000_0003);

        do_write(0, 32'h123, 4'hF, 0, 0, 0);
        @(negedge clk);
        bus.awvalid = 1; bus.awaddr = 7'(15 << 2); bus.wvalid = 1; bus.wdata = 32'h1; bus.wstrb = 4'hF;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("coinc.bvalid", bus.bvalid, 1'b1);
        bus.bready = 1;
        @(negedge clk);
        bus.bready = 0;
        m_frame();
        m_write(15, 32'h1, 4'hF);
        check_outputs("coinc");
        chk("coinc.bg_held", bg_color, 12'h000);
        do_read(14, 0);
        pulse_frame();
        chk("coinc.bg_applied", bg_color, 12'h123);

        do_write(6, 32'h0AA, 4'hF, 0, 0, 0);
        @(negedge clk);
        bus.awvalid = 1; bus.awaddr = 7'(6 << 2); bus.wvalid = 1; bus.wdata = 32'h155; bus.wstrb = 4'hF;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 1; bus.araddr = 7'(6 << 2);
        @(negedge clk);
        bus.arvalid = 0;
        chk("rw.bvalid", bus.bvalid, 1'b1);
        chk("rw.rvalid", bus.rvalid, 1'b1);
        chk("rw.rdata_old", bus.rdata, m_read(6));
        bus.bready = 1; bus.rready = 1;
        @(negedge clk);
        bus.bready = 0; bus.rready = 0;
        m_write(6, 32'h155, 4'hF);
        do_read(6, 0);

        for (int n = 0; n < 300; n++) begin
            int op, idx;
            op  = int'($urandom_range(0, 9));
            idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
            if (op < 5)
                do_write(idx, $urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)));
            else if (op < 8)
                do_read(idx, int'($urandom_range(0, 2)));
            else if (op == 8)
                pulse_frame();
            else
                do_write(15, 32'h1, 4'h1, 0, 0, 0);
        end
        do_read(14, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
